// File: rtl/branch_resolve_unit.sv
// Resolves fetch-time branch predictions in Execute: comb mispredict/redirect/flush, 1-cycle registered training strobe; no backpressure beyond stall_D/bubble_E.
// Optional BRANCH_RESOLVE_STATS_EN adds saturating branch/mispredict counters (and the CNT_W parameter).
module branch_resolve_unit #(
  parameter int PC_W = 32
`ifdef BRANCH_RESOLVE_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_F,
  input  logic            predict_taken_F,
  input  logic            stall_D,
  input  logic            bubble_E,
  input  logic            is_branch_E,
  input  logic            branch_taken_E,
  input  logic [PC_W-1:0] PC_E,
  input  logic [PC_W-1:0] target_E,
  output logic            mispredict_E,
  output logic [PC_W-1:0] redirect_pc_E,
  output logic            flush_D,
  output logic            flush_E,
  output logic            update_en,
  output logic [PC_W-1:0] PC_upd,
  output logic            branch_taken_upd,
  output logic            predicted_E
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
`endif
);

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_RECOVER = 1'b1;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic            valid_d_q, valid_d_d;
  logic            pred_d_q, pred_d_d;
  logic            valid_e_q, valid_e_d;
  logic            pred_e_q, pred_e_d;
  logic            state_q, state_d;
  logic            update_en_q, update_en_d;
  logic [PC_W-1:0] pc_upd_q, pc_upd_d;
  logic            branch_taken_upd_q, branch_taken_upd_d;
  logic            res;

  // The slot in E during RECOVER is the squashed one, so it never resolves.
  assign res           = valid_e_q & is_branch_E & (state_q == ST_RUN);
  assign mispredict_E  = res & (branch_taken_E != pred_e_q);
  assign redirect_pc_E = branch_taken_E ? target_E : (PC_E + PC_STEP);
  assign flush_D       = mispredict_E;
  assign flush_E       = mispredict_E;

  assign update_en        = update_en_q;
  assign PC_upd           = pc_upd_q;
  assign branch_taken_upd = branch_taken_upd_q;
  assign predicted_E      = pred_e_q;

  always_comb begin
    valid_d_d = valid_d_q;
    pred_d_d  = pred_d_q;
    if (flush_D) begin
      valid_d_d = 1'b0;
      pred_d_d  = 1'b0;
    end else if (!stall_D) begin
      valid_d_d = valid_F;
      pred_d_d  = predict_taken_F;
    end
  end

  always_comb begin
    valid_e_d = valid_d_q;
    pred_e_d  = pred_d_q;
    if (flush_E || bubble_E) begin
      valid_e_d = 1'b0;
      pred_e_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:     state_d = mispredict_E ? ST_RECOVER : ST_RUN;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    update_en_d        = res;
    pc_upd_d           = pc_upd_q;
    branch_taken_upd_d = branch_taken_upd_q;
    if (res) begin
      pc_upd_d           = PC_E;
      branch_taken_upd_d = branch_taken_E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d_q          <= 1'b0;
      pred_d_q           <= 1'b0;
      valid_e_q          <= 1'b0;
      pred_e_q           <= 1'b0;
      state_q            <= ST_RUN;
      update_en_q        <= 1'b0;
      pc_upd_q           <= '0;
      branch_taken_upd_q <= 1'b0;
    end else begin
      valid_d_q          <= valid_d_d;
      pred_d_q           <= pred_d_d;
      valid_e_q          <= valid_e_d;
      pred_e_q           <= pred_e_d;
      state_q            <= state_d;
      update_en_q        <= update_en_d;
      pc_upd_q           <= pc_upd_d;
      branch_taken_upd_q <= branch_taken_upd_d;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res && (branch_count_q != '1)) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (mispredict_E && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with a queue scoreboard for the training strobe.
module tb_branch_resolve_unit;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_F;
  logic            predict_taken_F;
  logic            stall_D;
  logic            bubble_E;
  logic            is_branch_E;
  logic            branch_taken_E;
  logic [PC_W-1:0] PC_E;
  logic [PC_W-1:0] target_E;
  logic            mispredict_E;
  logic [PC_W-1:0] redirect_pc_E;
  logic            flush_D;
  logic            flush_E;
  logic            update_en;
  logic [PC_W-1:0] PC_upd;
  logic            branch_taken_upd;
  logic            predicted_E;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic [PC_W:0] sb_q[$];

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_count, mispredict_count;
  logic [1:0]  branch_count_s, mispredict_count_s;
  logic        mp_s, fd_s, fe_s, ue_s, btu_s, pe_s;
  logic [PC_W-1:0] rp_s, pcu_s;

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .valid_F(valid_F), .predict_taken_F(predict_taken_F),
    .stall_D(stall_D), .bubble_E(bubble_E), .is_branch_E(is_branch_E),
    .branch_taken_E(branch_taken_E), .PC_E(PC_E), .target_E(target_E),
    .mispredict_E(mp_s), .redirect_pc_E(rp_s), .flush_D(fd_s), .flush_E(fe_s),
    .update_en(ue_s), .PC_upd(pcu_s), .branch_taken_upd(btu_s), .predicted_E(pe_s),
    .branch_count(branch_count_s), .mispredict_count(mispredict_count_s)
  );
`endif

  branch_resolve_unit #(
    .PC_W(PC_W)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .CNT_W(32)
`endif
  ) u_dut (
    .clk(clk), .rst(rst), .valid_F(valid_F), .predict_taken_F(predict_taken_F),
    .stall_D(stall_D), .bubble_E(bubble_E), .is_branch_E(is_branch_E),
    .branch_taken_E(branch_taken_E), .PC_E(PC_E), .target_E(target_E),
    .mispredict_E(mispredict_E), .redirect_pc_E(redirect_pc_E),
    .flush_D(flush_D), .flush_E(flush_E), .update_en(update_en),
    .PC_upd(PC_upd), .branch_taken_upd(branch_taken_upd), .predicted_E(predicted_E)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every resolving branch pushed before an edge must appear as update_en right after it.
  always begin
    logic [PC_W:0] exp_e;
    logic          exp_u;
    @(posedge clk);
    #1;
    if (mon_en) begin
      exp_u = (sb_q.size() != 0);
      total++;
      if (update_en !== exp_u) begin
        bad++;
        $display("FAIL sb_update_en got=%0b exp=%0b t=%0t", update_en, exp_u, $time);
        if (exp_u) void'(sb_q.pop_front());
      end else if (exp_u) begin
        exp_e = sb_q.pop_front();
        total++;
        if ({PC_upd, branch_taken_upd} !== exp_e) begin
          bad++;
          $display("FAIL sb_update_data got=%h/%0b exp=%h/%0b", PC_upd, branch_taken_upd,
                   exp_e[PC_W:1], exp_e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic p);
    is_branch_E     = 1'b0;
    valid_F         = 1'b1;
    predict_taken_F = p;
    step();
    valid_F         = 1'b0;
    predict_taken_F = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({update_en, PC_upd, branch_taken_upd, predicted_E} !== '0) begin
      bad++;
      $display("FAIL reset_regs got=%0b/%h/%0b/%0b exp=0/0/0/0", update_en, PC_upd,
               branch_taken_upd, predicted_E);
    end
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b1;
    #1;
    total++;
    if ({mispredict_E, flush_D, flush_E} !== 3'b000) begin
      bad++;
      $display("FAIL reset_no_mispredict got=%b exp=000", {mispredict_E, flush_D, flush_E});
    end
    is_branch_E    = 1'b0;
    branch_taken_E = 1'b0;
    rst            = 1'b0;
    mon_en         = 1'b1;
    step();
  endtask

  task automatic test_correct_not_taken();
    send(1'b0);
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b0;
    PC_E           = 32'h100;
    target_E       = 32'h500;
    sb_q.push_back({32'h100, 1'b0});
    #1;
    total++;
    if ({mispredict_E, flush_D, flush_E, predicted_E} !== 4'b0000) begin
      bad++;
      $display("FAIL cnt_no_flush got=%b exp=0000", {mispredict_E, flush_D, flush_E, predicted_E});
    end
    step();
    is_branch_E = 1'b0;
    total++;
    if ({update_en, PC_upd, branch_taken_upd} !== {1'b1, 32'h100, 1'b0}) begin
      bad++;
      $display("FAIL cnt_update got=%0b/%h/%0b exp=1/100/0", update_en, PC_upd, branch_taken_upd);
    end
    step();
  endtask

  task automatic test_mispredict_taken();
    send(1'b0);
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b1;
    PC_E           = 32'h180;
    target_E       = 32'h200;
    sb_q.push_back({32'h180, 1'b1});
    #1;
    total++;
    if ({mispredict_E, flush_D, flush_E} !== 3'b111) begin
      bad++;
      $display("FAIL mpt_flush got=%b exp=111", {mispredict_E, flush_D, flush_E});
    end
    total++;
    if (redirect_pc_E !== 32'h200) begin
      bad++;
      $display("FAIL mpt_redirect got=%h exp=00000200", redirect_pc_E);
    end
    step();
    #1;
    total++;
    if ({mispredict_E, flush_D, flush_E} !== 3'b000) begin
      bad++;
      $display("FAIL mpt_recover_quiet got=%b exp=000", {mispredict_E, flush_D, flush_E});
    end
    total++;
    if ({update_en, PC_upd, branch_taken_upd} !== {1'b1, 32'h180, 1'b1}) begin
      bad++;
      $display("FAIL mpt_update got=%0b/%h/%0b exp=1/180/1", update_en, PC_upd, branch_taken_upd);
    end
    step();
    is_branch_E = 1'b0;
  endtask

  task automatic test_mispredict_not_taken();
    logic [PC_W-1:0] pcs [2];
    logic [PC_W-1:0] exps[2];
    pcs[0] = 32'h3FC;      exps[0] = 32'h400;
    pcs[1] = 32'hFFFFFFFC; exps[1] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      send(1'b1);
      is_branch_E    = 1'b1;
      branch_taken_E = 1'b0;
      PC_E           = pcs[i];
      target_E       = 32'h999;
      sb_q.push_back({pcs[i], 1'b0});
      #1;
      total++;
      if ({mispredict_E, redirect_pc_E} !== {1'b1, exps[i]}) begin
        bad++;
        $display("FAIL mpnt_redirect_%0d got=%0b/%h exp=1/%h", i, mispredict_E, redirect_pc_E, exps[i]);
      end
      step();
      is_branch_E = 1'b0;
      step();
    end
  endtask

  task automatic test_non_branch();
    send(1'b1);
    is_branch_E    = 1'b0;
    branch_taken_E = 1'b0;
    PC_E           = 32'h140;
    #1;
    total++;
    if ({predicted_E, mispredict_E} !== 2'b10) begin
      bad++;
      $display("FAIL nonbranch got=%b exp=10", {predicted_E, mispredict_E});
    end
    step();
    step();
  endtask

  task automatic test_stall_bubble();
    is_branch_E     = 1'b0;
    valid_F         = 1'b1;
    predict_taken_F = 1'b1;
    step();
    predict_taken_F = 1'b0;
    stall_D         = 1'b1;
    bubble_E        = 1'b1;
    is_branch_E     = 1'b1;
    branch_taken_E  = 1'b0;
    PC_E            = 32'h300;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (mispredict_E !== 1'b0) begin
        bad++;
        $display("FAIL stall_no_resolve_%0d got=%0b exp=0", i, mispredict_E);
      end
      step();
    end
    stall_D     = 1'b0;
    bubble_E    = 1'b0;
    valid_F     = 1'b0;
    is_branch_E = 1'b0;
    step();
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b1;
    PC_E           = 32'h340;
    sb_q.push_back({32'h340, 1'b1});
    #1;
    total++;
    if ({predicted_E, mispredict_E} !== 2'b10) begin
      bad++;
      $display("FAIL stall_release got=%b exp=10", {predicted_E, mispredict_E});
    end
    step();
    is_branch_E = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_F         = (i < 4);
      predict_taken_F = (i < 4) ? pat[i] : 1'b0;
      if (i >= 2) begin
        is_branch_E    = 1'b1;
        branch_taken_E = pat[i-2];
        PC_E           = 32'h400 + 32'(i * 4);
        sb_q.push_back({32'h400 + 32'(i * 4), pat[i-2]});
        #1;
        total++;
        if ({predicted_E, mispredict_E} !== {pat[i-2], 1'b0}) begin
          bad++;
          $display("FAIL b2b_%0d got=%b exp=%b", i, {predicted_E, mispredict_E}, {pat[i-2], 1'b0});
        end
      end else begin
        is_branch_E = 1'b0;
      end
      step();
    end
    valid_F     = 1'b0;
    is_branch_E = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    send(1'b0);
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b1;
    PC_E           = 32'h500;
    target_E       = 32'h600;
    rst            = 1'b1;
    #1;
    total++;
    if (mispredict_E !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got=%0b exp=1", mispredict_E);
    end
    step();
    #1;
    total++;
    if ({update_en, predicted_E, mispredict_E} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_cleared got=%b exp=000", {update_en, predicted_E, mispredict_E});
    end
    rst = 1'b0;
    send(1'b1);
    is_branch_E    = 1'b1;
    branch_taken_E = 1'b1;
    PC_E           = 32'h520;
    sb_q.push_back({32'h520, 1'b1});
    step();
    is_branch_E = 1'b0;
    step();
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats();
    logic pr[5];
    logic tk[5];
    pr[0] = 0; tk[0] = 0;
    pr[1] = 0; tk[1] = 1;
    pr[2] = 1; tk[2] = 1;
    pr[3] = 1; tk[3] = 0;
    pr[4] = 0; tk[4] = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(pr[i]);
      is_branch_E    = 1'b1;
      branch_taken_E = tk[i];
      PC_E           = 32'h700 + 32'(i * 4);
      sb_q.push_back({32'h700 + 32'(i * 4), tk[i]});
      step();
      is_branch_E = 1'b0;
      step();
    end
    total++;
    if ({branch_count, mispredict_count} !== {32'd5, 32'd2}) begin
      bad++;
      $display("FAIL stats_counts got=%0d/%0d exp=5/2", branch_count, mispredict_count);
    end
    total++;
    if ({branch_count_s, mispredict_count_s} !== {2'd3, 2'd2}) begin
      bad++;
      $display("FAIL stats_saturate got=%0d/%0d exp=3/2", branch_count_s, mispredict_count_s);
    end
  endtask
`endif

  initial begin
    rst             = 1'b1;
    valid_F         = 1'b0;
    predict_taken_F = 1'b0;
    stall_D         = 1'b0;
    bubble_E        = 1'b0;
    is_branch_E     = 1'b0;
    branch_taken_E  = 1'b0;
    PC_E            = '0;
    target_E        = '0;
    test_reset();
    test_correct_not_taken();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_non_branch();
    test_stall_bubble();
    test_back_to_back();
    test_reset_midflight();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    step();
    step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drained got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
